inst_encoder: RTL
=================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  encode request valid.
- req_ready  out  1  encoder can accept a request.
- req_cls  in  4  class: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 SYSTEM; 10-15 illegal.
- req_funct3  in  3  funct3 field.
- req_alt  in  2  funct7 select: 0 = 0000000, 1 = 0100000, 2 = 0000001 (M extension), 3 illegal.
- req_rs1, req_rs2, req_rd  in  5 each  register indices.
- req_imm  in  32  immediate value, or CSR address, or uimm.
- inst_valid  out  1  encoded word valid.
- inst_ready  in  1  consumer accepts word.
- inst  out  32  encoded RV32 instruction.
- inst_err  out  1  request was illegal or out of range.
- enc_count  out  16  saturating count of words accepted by the consumer with inst_err=0.
REQ-002 Only clk exists as a clock; rst is synchronous and active-high.

Function
REQ-003 The block SHALL be two stages (S1 request register, S2 output register); latency from req accept to inst_valid SHALL be 2 cycles.
REQ-004 A transfer SHALL occur on a cycle where valid and ready are both 1; inst/inst_err SHALL hold stable while inst_valid=1 and inst_ready=0.
REQ-005 req_ready SHALL be !S1_full | (S1 advances this cycle); S1 advances when !S2_full | inst_ready; sustained throughput SHALL be 1 word/cycle with inst_ready=1.
REQ-006 Opcodes SHALL be 0x33, 0x13, 0x03, 0x23, 0x63, 0x37, 0x17, 0x6F, 0x67, 0x73 for classes 0-9.
REQ-007 Immediate placement SHALL follow RV32 I/S/B/U/J formats; B and J drop imm[0].
REQ-008 inst_err SHALL be 1 and inst 32'h0 when any of these holds:
- req_cls >= 10.
- R with an illegal funct3/alt combination: alt=1 is legal only for funct3 0 and 5; alt=3 is never legal.
- I/LOAD/STORE/JALR imm outside signed 12-bit.
- BRANCH imm outside signed 13-bit or odd.
- JAL imm outside signed 21-bit or odd.
- LUI/AUIPC imm[11:0] != 0.
- SLLI/SRLI/SRAI with imm[31:5] != 0; SRAI is selected by alt=1.
- LOAD funct3 not in {0,1,2,4,5}.
- STORE funct3 > 2.
- BRANCH funct3 of 2 or 3.
- JALR funct3 != 0.
- SYSTEM funct3=4.
- CSR imm[31:12] != 0.
- SYSTEM funct3=0 with imm not in {0x000, 0x001, 0x302}.
REQ-009 For SYSTEM with funct3 in {1,2,3,5,6,7}, imm[11:0] SHALL go to bits 31:20, req_rs1 to bits 19:15 (uimm for 5-7), and req_rd to bits 11:7.
REQ-010 For SYSTEM with funct3=0, the output SHALL be imm<<20 | 0x73 with rs1/rd fields 0 (ECALL, EBREAK, MRET).
REQ-011 Fields unused by a format SHALL be 0; rs2 in I-ALU shifts SHALL come from imm[4:0].
REQ-012 enc_count SHALL increment only on an output transfer with inst_err=0, and SHALL saturate at 16'hFFFF.
REQ-013 A simultaneous S1→S2 move and new request accept SHALL lose no data and duplicate none.

Reset
REQ-014 While rst=1 at a clk edge:
- both stages SHALL be emptied.
- inst_valid=0, inst=0, inst_err=0, enc_count=0, req_ready=0.
- in-flight requests SHALL be discarded.
REQ-015 req_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-016 Macro INST_ENCODER_MEXT_EN:
- Defined: req_alt=2 with R class encodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (funct7 0000001).
- Undefined: any req_alt=2 request SHALL produce inst_err=1, inst=0.

Verification
REQ-017 ADDI x1,x0,5 (cls1, f3 0, rd1, imm5) -> inst 0x00500093 two cycles after accept, inst_err 0.
REQ-018 SUB x3,x1,x2 (cls0, alt1) -> 0x402081B3; MUL x5,x6,x7 (cls0, alt2) -> 0x027302B3 with macro defined, or inst_err=1, inst=0 without it.
REQ-019 BEQ x1,x2,+8 -> 0x00208463; JAL x1,+2048 -> 0x001000EF; BEQ with imm=7 -> inst_err=1, inst=0.
REQ-020 Hold inst_ready=0 and issue 3 requests -> first two accepted, req_ready=0 on the third, inst stable; release inst_ready -> all 3 words appear in order with no gap.
REQ-021 Assert rst with both stages full -> next cycle inst_valid=0 and enc_count=0; SYSTEM imm=1 afterwards -> 0x00100073.
REQ-022 Preload enc_count to 0xFFFE, then 3 good transfers -> enc_count ends at 0xFFFF.

Source files
------------

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - two-stage RV32 instruction encoder with valid/ready handshakes
//
// Purpose: accepts an instruction description (class, funct3, funct7 select,
// register indices, immediate) and emits the encoded RV32 word, or an error
// flag with a zero word when the request cannot be encoded.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_cls, req_funct3,
//   req_alt, req_rs1/rs2/rd,
//   req_imm                  request fields
//   inst_valid / inst_ready  output handshake
//   inst, inst_err           encoded word and error flag
//   enc_count                saturating count of good words delivered
//
// Configuration macro: INST_ENCODER_MEXT_EN enables M-extension R-type
// encodings (req_alt = 2).

module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cls,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_alt,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_imm,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        inst_err,
  output logic [15:0] enc_count
);

`ifdef INST_ENCODER_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  // S1: registered request
  logic        s1_full_q, s1_full_d;
  logic [3:0]  s1_cls_q, s1_cls_d;
  logic [2:0]  s1_f3_q, s1_f3_d;
  logic [1:0]  s1_alt_q, s1_alt_d;
  logic [4:0]  s1_rs1_q, s1_rs1_d;
  logic [4:0]  s1_rs2_q, s1_rs2_d;
  logic [4:0]  s1_rd_q, s1_rd_d;
  logic [31:0] s1_imm_q, s1_imm_d;
  // S2: registered result
  logic        s2_full_q, s2_full_d;
  logic [31:0] s2_inst_q, s2_inst_d;
  logic        s2_err_q, s2_err_d;
  logic [15:0] cnt_q, cnt_d;

  logic        s1_adv;
  logic        accept;
  logic [31:0] enc_word;
  logic        enc_err;
  logic [6:0]  f7;
  logic        imm12_ok, imm13_ok, imm21_ok;

  // Encoder: combinational from S1 contents
  always_comb begin
    enc_word = 32'h0;
    enc_err  = 1'b0;
    f7       = 7'h00;
    // Signed-range checks: all bits above the sign bit must match it
    imm12_ok = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
    imm13_ok = (&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]);
    imm21_ok = (&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]);
    case (s1_cls_q)
      4'd0: begin
        case (s1_alt_q)
          2'd0: f7 = 7'h00;
          2'd1: begin
            f7 = 7'h20;
            if (s1_f3_q != 3'd0 && s1_f3_q != 3'd5) enc_err = 1'b1;
          end
          2'd2: begin
            f7 = 7'h01;
            if (!MEXT) enc_err = 1'b1;
          end
          default: enc_err = 1'b1;
        endcase
        enc_word = {f7, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, 7'h33};
      end
      4'd1: begin
        if (s1_f3_q == 3'd1 || s1_f3_q == 3'd5) begin
          // Shifts: shamt from imm[4:0]; alt=1 selects SRAI, only on funct3 5
          if (s1_imm_q[31:5] != 27'd0) enc_err = 1'b1;
          if (s1_alt_q[1] || (s1_alt_q[0] && s1_f3_q == 3'd1)) enc_err = 1'b1;
          f7 = s1_alt_q[0] ? 7'h20 : 7'h00;
          enc_word = {f7, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, 7'h13};
        end else begin
          if (!imm12_ok) enc_err = 1'b1;
          enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, 7'h13};
        end
      end
      4'd2: begin
        if (s1_f3_q == 3'd3 || s1_f3_q == 3'd6 || s1_f3_q == 3'd7 || !imm12_ok) enc_err = 1'b1;
        enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, 7'h03};
      end
      4'd3: begin
        if (s1_f3_q > 3'd2 || !imm12_ok) enc_err = 1'b1;
        enc_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], 7'h23};
      end
      4'd4: begin
        if (s1_f3_q == 3'd2 || s1_f3_q == 3'd3 || !imm13_ok || s1_imm_q[0]) enc_err = 1'b1;
        enc_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                    s1_imm_q[4:1], s1_imm_q[11], 7'h63};
      end
      4'd5, 4'd6: begin
        if (s1_imm_q[11:0] != 12'd0) enc_err = 1'b1;
        enc_word = {s1_imm_q[31:12], s1_rd_q, (s1_cls_q == 4'd5) ? 7'h37 : 7'h17};
      end
      4'd7: begin
        if (!imm21_ok || s1_imm_q[0]) enc_err = 1'b1;
        enc_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                    s1_rd_q, 7'h6F};
      end
      4'd8: begin
        if (s1_f3_q != 3'd0 || !imm12_ok) enc_err = 1'b1;
        enc_word = {s1_imm_q[11:0], s1_rs1_q, 3'd0, s1_rd_q, 7'h67};
      end
      4'd9: begin
        if (s1_f3_q == 3'd0) begin
          // ECALL / EBREAK / MRET: register fields forced to zero
          if (s1_imm_q != 32'h000 && s1_imm_q != 32'h001 && s1_imm_q != 32'h302) enc_err = 1'b1;
          enc_word = {s1_imm_q[11:0], 20'h00073};
        end else if (s1_f3_q == 3'd4) begin
          enc_err = 1'b1;
        end else begin
          if (s1_imm_q[31:12] != 20'd0) enc_err = 1'b1;
          enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, 7'h73};
        end
      end
      default: enc_err = 1'b1;
    endcase
    // Any funct7=0000001 request is rejected when M is not built in
    if (!MEXT && s1_alt_q == 2'd2) enc_err = 1'b1;
    if (enc_err) enc_word = 32'h0;
  end

  // Handshake and next-state
  always_comb begin
    s1_adv    = !s2_full_q || inst_ready;
    req_ready = !rst && (!s1_full_q || s1_adv);
    accept    = req_valid && req_ready;

    s1_cls_d  = s1_cls_q;
    s1_f3_d   = s1_f3_q;
    s1_alt_d  = s1_alt_q;
    s1_rs1_d  = s1_rs1_q;
    s1_rs2_d  = s1_rs2_q;
    s1_rd_d   = s1_rd_q;
    s1_imm_d  = s1_imm_q;
    s1_full_d = s1_full_q;
    s2_full_d = s2_full_q;
    s2_inst_d = s2_inst_q;
    s2_err_d  = s2_err_q;
    cnt_d     = cnt_q;

    // S1 drains into S2 and refills from the request port in the same cycle
    if (s1_adv) begin
      s2_full_d = s1_full_q;
      s2_inst_d = s1_full_q ? enc_word : 32'h0;
      s2_err_d  = s1_full_q & enc_err;
      s1_full_d = 1'b0;
    end
    if (accept) begin
      s1_full_d = 1'b1;
      s1_cls_d  = req_cls;
      s1_f3_d   = req_funct3;
      s1_alt_d  = req_alt;
      s1_rs1_d  = req_rs1;
      s1_rs2_d  = req_rs2;
      s1_rd_d   = req_rd;
      s1_imm_d  = req_imm;
    end
    if (s2_full_q && inst_ready && !s2_err_q && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full_q <= 1'b0;
      s1_cls_q  <= 4'd0;
      s1_f3_q   <= 3'd0;
      s1_alt_q  <= 2'd0;
      s1_rs1_q  <= 5'd0;
      s1_rs2_q  <= 5'd0;
      s1_rd_q   <= 5'd0;
      s1_imm_q  <= 32'd0;
      s2_full_q <= 1'b0;
      s2_inst_q <= 32'd0;
      s2_err_q  <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      s1_full_q <= s1_full_d;
      s1_cls_q  <= s1_cls_d;
      s1_f3_q   <= s1_f3_d;
      s1_alt_q  <= s1_alt_d;
      s1_rs1_q  <= s1_rs1_d;
      s1_rs2_q  <= s1_rs2_d;
      s1_rd_q   <= s1_rd_d;
      s1_imm_q  <= s1_imm_d;
      s2_full_q <= s2_full_d;
      s2_inst_q <= s2_inst_d;
      s2_err_q  <= s2_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign inst_valid = s2_full_q;
  assign inst       = s2_inst_q;
  assign inst_err   = s2_err_q;
  assign enc_count  = cnt_q;

endmodule
